// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receiver, LSB first, with framing-error flag.
// Define UART_RX_PARITY_EN to add an even-parity bit and a live parity_err output.
module uart_rx #(
    parameter int data_size  = 8,
    parameter int stop_ticks = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_tick,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err
);
    localparam logic [3:0] StopLast = 4'(stop_ticks - 1);
    localparam logic [2:0] DataLast = 3'(data_size - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state_q;
    logic [1:0]             sync_q;
    logic                   rx_s;
    logic [3:0]             s_q;
    logic [2:0]             n_q;
    logic [data_size-1:0]   b_q;
    logic [7:0]             dout_q;
    logic                   rx_done_q;
    logic                   frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic                   p_q;
    logic                   parity_err_q;
`endif

    // The line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            s_q          <= 4'd0;
            n_q          <= 3'd0;
            b_q          <= '0;
            dout_q       <= 8'd0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            p_q          <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        s_q     <= 4'd0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_q == 4'd7) begin
                            if (!rx_s) begin
                                s_q     <= 4'd0;
                                n_q     <= 3'd0;
                                state_q <= DATA;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            s_q <= s_q + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_q == 4'd15) begin
                            s_q <= 4'd0;
                            b_q <= {rx_s, b_q[data_size-1:1]};
                            if (n_q == DataLast) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= PARITY;
`else
                                state_q <= STOP;
`endif
                            end else begin
                                n_q <= n_q + 3'd1;
                            end
                        end else begin
                            s_q <= s_q + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (s_tick) begin
                        if (s_q == 4'd15) begin
                            p_q     <= rx_s;
                            s_q     <= 4'd0;
                            state_q <= STOP;
                        end else begin
                            s_q <= s_q + 4'd1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (s_tick) begin
                        if (s_q == StopLast) begin
                            dout_q       <= 8'(b_q);
                            frame_err_q  <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= (^b_q) ^ p_q;
`endif
                            rx_done_q    <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            s_q <= s_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dout      = dout_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level scoreboard for uart_rx plus literal end-of-test-step checks.
// Optional parity frames are exercised when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
    localparam int BitClks = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic       s_tick;
    logic [7:0] dout;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;
    logic [1:0] tickDiv = 2'd0;

    int         assertCount = 0;
    int         failCount   = 0;
    int         doneCount   = 0;
    logic [7:0] modelDout   = 8'd0;
    logic       modelFe     = 1'b0;
    logic       modelPe     = 1'b0;
    logic [9:0] expQ[$];

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .s_tick    (s_tick),
        .rx        (rx),
        .dout      (dout),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    // One s_tick every 4 clocks, so a 16-tick bit is exactly BitClks clocks.
    always @(posedge clk) tickDiv <= tickDiv + 2'd1;
    assign s_tick = (tickDiv == 2'd0);

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic holdClks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every cycle: a completed frame must match the oldest sent frame, otherwise outputs hold.
    task automatic compareCycle();
        logic [9:0] e;
        @(negedge clk);
        if (!rst) begin
            modelDout = 8'd0;
            modelFe   = 1'b0;
            modelPe   = 1'b0;
            expQ.delete();
            check("rx_done in reset", {7'd0, rx_done}, 8'd0);
        end else if (rx_done) begin
            doneCount++;
            if (expQ.size() == 0) begin
                check("unexpected rx_done", {7'd0, rx_done}, 8'd0);
            end else begin
                e         = expQ.pop_front();
                modelDout = e[7:0];
                modelFe   = e[8];
                modelPe   = e[9];
            end
        end
        check("dout", dout, modelDout);
        check("frame_err", {7'd0, frame_err}, {7'd0, modelFe});
        check("parity_err", {7'd0, parity_err}, {7'd0, modelPe});
    endtask

    // Sends one frame; the stop level is released high once past its sampling point.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parityBit);
        logic pe;
        pe = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe = (^data) ^ parityBit;
`endif
        expQ.push_back({pe, ~stopBit, data});
        rx = 1'b0;
        holdClks(BitClks);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            holdClks(BitClks);
        end
`ifdef UART_RX_PARITY_EN
        rx = parityBit;
        holdClks(BitClks);
`endif
        rx = stopBit;
        holdClks(40);
        rx = 1'b1;
        holdClks(BitClks - 40);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expDout, input logic expFe,
                               input logic expPe, input int expDone);
        int waited;
        waited = 0;
        while (expQ.size() != 0 && waited < 4 * BitClks) begin
            @(negedge clk);
            waited++;
        end
        if (expQ.size() != 0) check({name, " frame pending"}, 8'(expQ.size()), 8'd0);
        @(posedge clk);
        #1;
        check({name, " dout"}, dout, expDout);
        check({name, " frame_err"}, {7'd0, frame_err}, {7'd0, expFe});
        check({name, " parity_err"}, {7'd0, parity_err}, {7'd0, expPe});
        check({name, " rx_done count"}, 8'(doneCount), 8'(expDone));
    endtask

    initial begin
        logic [7:0] partial;
        fork
            forever compareCycle();
        join_none

        holdClks(5);
        @(posedge clk);
        #1 rst = 1'b1;
        holdClks(BitClks);
        checkOutput("reset state", 8'h00, 1'b0, 1'b0, 0);

        applyStimulus(8'hA5, 1'b1, ^8'hA5);
        checkOutput("frame A5", 8'hA5, 1'b0, 1'b0, 1);

        rx = 1'b0;
        holdClks(16);
        rx = 1'b1;
        holdClks(2 * BitClks);
        checkOutput("glitch", 8'hA5, 1'b0, 1'b0, 1);

        applyStimulus(8'h3C, 1'b0, ^8'h3C);
        checkOutput("bad stop 3C", 8'h3C, 1'b1, 1'b0, 2);
        holdClks(BitClks);
        applyStimulus(8'h11, 1'b1, ^8'h11);
        checkOutput("frame 11", 8'h11, 1'b0, 1'b0, 3);

        applyStimulus(8'h00, 1'b1, ^8'h00);
        applyStimulus(8'hFF, 1'b1, ^8'hFF);
        checkOutput("back-to-back FF", 8'hFF, 1'b0, 1'b0, 5);

        partial = 8'h5A;
        rx = 1'b0;
        holdClks(BitClks);
        for (int i = 0; i < 3; i++) begin
            rx = partial[i];
            holdClks(BitClks);
        end
        rx = partial[3];
        holdClks(32);
        @(posedge clk);
        #1 rst = 1'b0;
        rx = 1'b1;
        holdClks(10);
        checkOutput("mid-frame reset", 8'h00, 1'b0, 1'b0, 5);
        @(posedge clk);
        #1 rst = 1'b1;
        holdClks(BitClks);
        checkOutput("after reset", 8'h00, 1'b0, 1'b0, 5);
        applyStimulus(8'h81, 1'b1, ^8'h81);
        checkOutput("frame 81", 8'h81, 1'b0, 1'b0, 6);

`ifdef UART_RX_PARITY_EN
        applyStimulus(8'h07, 1'b1, 1'b1);
        checkOutput("parity ok 07", 8'h07, 1'b0, 1'b0, 7);
        applyStimulus(8'h07, 1'b1, 1'b0);
        checkOutput("parity bad 07", 8'h07, 1'b0, 1'b1, 8);
`endif

        holdClks(BitClks);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, 16x oversampled, LSB first. It is the receive counterpart of the team's UART transmitter and is driven by the same shared baud-tick generator (`s_tick`, 16 ticks per bit). It deserialises one frame per start bit and presents the byte on `dout` with a one-clock `rx_done` pulse. It also flags framing errors and, optionally, parity errors.

## Interface
- `data_size`, 8: data bits per frame, range 5–8.
- `stop_ticks`, 16: s_tick count for the stop bit. 16 = 1 stop bit; must be ≤16.
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `s_tick` input 1: one-clk-wide oversample enable, 16 per bit period.
- `rx` input 1: serial line, idle high, asynchronous to `clk`.
- `dout` output 8: last received byte. Right-aligned; unused MSBs are 0 when `data_size` < 8.
- `rx_done` output 1: one-clk pulse when `dout` and the error flags update.
- `frame_err` output 1: stop bit sampled low in the last frame.
- `parity_err` output 1: parity mismatch in the last frame. Tied 0 unless `UART_RX_PARITY_EN` is defined.

## Operation
- `rx` passes through a 2-FF synchronizer. The synchronizer resets to 1. All FSM decisions use the synchronized value `rx_s`.
- Counters:
  - 4-bit tick counter `s`.
  - 3-bit bit counter `n`.
  - `data_size`-wide shift register `b`, filled by right shift: `b <= {rx_s, b[data_size-1:1]}`.
- FSM states: `IDLE`, `START`, `DATA`, `PARITY` (only with the macro), `STOP`.
- `IDLE`:
  - When `rx_s`==0, clear `s` and go to `START`.
  - `s_tick` is not required to leave `IDLE`.
- `START`, on each `s_tick`:
  - At `s`==7 (mid start bit), re-check the line.
  - If `rx_s`==0: clear `s` and `n`, go to `DATA`.
  - If `rx_s`==1: false start; return to `IDLE` with no `rx_done` and no output change.
  - Otherwise increment `s`.
- `DATA`, on each `s_tick`:
  - At `s`==15 (mid bit): shift in `rx_s` and clear `s`.
  - If `n`==`data_size`-1, go to `PARITY` (with the macro) or `STOP` (without). Otherwise increment `n`.
  - Otherwise increment `s`.
- `STOP`, on each `s_tick`:
  - At `s`==`stop_ticks`-1, sample `rx_s` and return to `IDLE`.
  - In the same cycle, register: `dout` <= `b` (zero-extended), `frame_err` <= ~`rx_s`, and `parity_err`.
  - Assert `rx_done` for exactly the next clk.
- `dout`, `frame_err` and `parity_err` hold until the next completed frame; no handshake back-pressure.
- An overrun cannot occur: at most one frame completes per `data_size`+2 bit periods, and `dout` is simply overwritten.
- A low `rx_s` seen in `IDLE` immediately after `STOP` starts a new frame. This allows back-to-back frames.

## Timing
- Reset values: FSM `IDLE`, `s`=0, `n`=0, `b`=0, `dout`=0, `rx_done`=0, `frame_err`=0, `parity_err`=0.
- Reset asserted mid-frame aborts the frame immediately. No `rx_done` follows.
- Start detection: 2 clk from the `rx` falling edge to `START`, due to the synchronizer.
- Bit sampling happens 8 ticks (±1 tick plus sync latency) after each nominal bit edge.
- `rx_done` is registered and rises 1 clk after the final stop `s_tick`. Outputs are valid in the same cycle `rx_done` is high.
- Only the `s_tick` cycles advance `s`. Between ticks the FSM holds.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds the `PARITY` state, one bit long.
  - At `s`==15, sample the parity bit `p`, clear `s`, go to `STOP`.
  - `parity_err` = (^`b`) ^ `p` for even parity, latched at `rx_done`.
- `UART_RX_PARITY_EN` undefined: no `PARITY` state; `DATA` goes directly to `STOP`; `parity_err` is constant 0.

## Test plan
- Frame 0xA5, valid stop bit, 16 ticks/bit -> single `rx_done` pulse, `dout`=0xA5, `frame_err`=0.
- Low glitch on `rx` lasting 4 ticks in `IDLE` -> `START` aborts at `s`==7; no `rx_done`; `dout` keeps its previous value.
- Frame 0x3C with the stop bit driven 0 -> `rx_done`, `dout`=0x3C, `frame_err`=1. The following good frame 0x11 gives `frame_err`=0.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two `rx_done` pulses, `dout`=0x00 then 0xFF.
- `rst` low during data bit 3 of 0x5A, then released, then frame 0x81 -> outputs at reset values until the first `rx_done`, then `dout`=0x81.
- With `UART_RX_PARITY_EN`: frame 0x07 with parity bit 1 -> `parity_err`=0; same frame with parity bit 0 -> `parity_err`=1.
